// File: rtl/user_edge_dma_accel_if.sv
// OBI request/response bundle used for both the accelerator's register port and its memory port.
interface user_edge_dma_accel_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;
  logic [ID_WIDTH-1:0]   id;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_WIDTH-1:0]   rid;
  logic                  err;

  modport master (output req, addr, wdata, we, id, input gnt, rvalid, rdata, rid, err);
  modport slave  (input req, addr, wdata, we, id, output gnt, rvalid, rdata, rid, err);
endinterface

// File: rtl/user_edge_dma_accel.sv
// Register-programmed streaming pixel accelerator: reads SRC words, applies a lane op, writes DST.
// Optional feature macro: USER_EDGE_GRAD_EN enables the horizontal-gradient mode (MODE=2).
module user_edge_dma_accel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int PIX_WIDTH  = 8,
  parameter int LEN_WIDTH  = 16
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  user_edge_dma_accel_if.slave  sbr_obi,
  user_edge_dma_accel_if.master mgr_obi
);
  localparam int LANES = DATA_WIDTH / PIX_WIDTH;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_SRC    = 3'd1;
  localparam logic [2:0] REG_DST    = 3'd2;
  localparam logic [2:0] REG_LEN    = 3'd3;
  localparam logic [2:0] REG_PARAM  = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(32'd4);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(32'd1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } state_e;

  state_e                state_r, state_s;
  logic [1:0]            mode_r;
  logic [ADDR_WIDTH-1:0] src_r, dst_r, src_ptr_r, dst_ptr_r;
  logic [LEN_WIDTH-1:0]  len_r, remain_r;
  logic [PIX_WIDTH-1:0]  param_r;
  logic                  done_r, err_flag_r;

  logic                  mgr_req_r, mgr_we_r, req_s, we_s;
  logic [ADDR_WIDTH-1:0] mgr_addr_r, addr_s;
  logic [DATA_WIDTH-1:0] mgr_wdata_r, result_s, op_s;

  logic                  sbr_rvalid_r, sbr_err_r;
  logic [DATA_WIDTH-1:0] sbr_rdata_r, rd_data_s;
  logic [ID_WIDTH-1:0]   sbr_rid_r;

  logic [2:0] reg_idx_s;
  logic       busy_s, cfg_reg_s, wr_s, cfg_wr_ok_s, status_wr_s, start_s, launch_s;
  logic       sbr_err_s, capture_s, wr_done_s, done_set_s, err_set_s;
  logic       unused_s;

  assign reg_idx_s   = sbr_obi.addr[4:2];
  assign busy_s      = (state_r != ST_IDLE);
  assign cfg_reg_s   = (reg_idx_s <= REG_PARAM);
  assign wr_s        = sbr_obi.req & sbr_obi.we;
  assign cfg_wr_ok_s = wr_s & cfg_reg_s & ~busy_s;
  assign status_wr_s = wr_s & (reg_idx_s == REG_STATUS);
  assign start_s     = cfg_wr_ok_s & (reg_idx_s == REG_CTRL) & sbr_obi.wdata[0];
  assign launch_s    = start_s & (len_r != {LEN_WIDTH{1'b0}});
  assign sbr_err_s   = (reg_idx_s >= 3'd6) | (wr_s & cfg_reg_s & busy_s);
  assign capture_s   = (state_r == ST_RD_WAIT) & mgr_obi.rvalid & ~mgr_obi.err;
  assign wr_done_s   = (state_r == ST_WR_WAIT) & mgr_obi.rvalid & ~mgr_obi.err;
  assign unused_s    = ^{sbr_obi.addr[ADDR_WIDTH-1:5], sbr_obi.addr[1:0], mgr_obi.rid};

  assign sbr_obi.gnt    = sbr_obi.req;
  assign sbr_obi.rvalid = sbr_rvalid_r;
  assign sbr_obi.rdata  = sbr_rdata_r;
  assign sbr_obi.rid    = sbr_rid_r;
  assign sbr_obi.err    = sbr_err_r;

  assign mgr_obi.req   = mgr_req_r;
  assign mgr_obi.addr  = mgr_addr_r;
  assign mgr_obi.wdata = mgr_wdata_r;
  assign mgr_obi.we    = mgr_we_r;
  assign mgr_obi.id    = {ID_WIDTH{1'b0}};

  // Copy, shift and threshold lane ops; any other mode passes the word through.
  function automatic logic [DATA_WIDTH-1:0] pixel_op(input logic [1:0]            mode,
                                                     input logic [DATA_WIDTH-1:0] word,
                                                     input logic [PIX_WIDTH-1:0]  param);
    logic [DATA_WIDTH-1:0] res;
    logic [PIX_WIDTH-1:0]  p;
    res = word;
    for (int k = 0; k < LANES; k++) begin
      p = word[k*PIX_WIDTH +: PIX_WIDTH];
      case (mode)
        2'd1:    res[k*PIX_WIDTH +: PIX_WIDTH] = p >> param[2:0];
        2'd3:    res[k*PIX_WIDTH +: PIX_WIDTH] = (p >= param) ? {PIX_WIDTH{1'b1}} : {PIX_WIDTH{1'b0}};
        default: res[k*PIX_WIDTH +: PIX_WIDTH] = p;
      endcase
    end
    return res;
  endfunction

  assign op_s = pixel_op(mode_r, mgr_obi.rdata, param_r);

`ifdef USER_EDGE_GRAD_EN
  logic [PIX_WIDTH-1:0]  prev_pix_r;
  logic                  first_r;
  logic [DATA_WIDTH-1:0] left_word_s, grad_s;

  // Lane k of left_word_s is the pixel to the left of lane k in the current word.
  always_comb begin
    left_word_s = {mgr_obi.rdata[DATA_WIDTH-PIX_WIDTH-1:0],
                   first_r ? mgr_obi.rdata[PIX_WIDTH-1:0] : prev_pix_r};
    grad_s = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      if (mgr_obi.rdata[k*PIX_WIDTH +: PIX_WIDTH] >= left_word_s[k*PIX_WIDTH +: PIX_WIDTH]) begin
        grad_s[k*PIX_WIDTH +: PIX_WIDTH] = mgr_obi.rdata[k*PIX_WIDTH +: PIX_WIDTH]
                                         - left_word_s[k*PIX_WIDTH +: PIX_WIDTH];
      end else begin
        grad_s[k*PIX_WIDTH +: PIX_WIDTH] = left_word_s[k*PIX_WIDTH +: PIX_WIDTH]
                                         - mgr_obi.rdata[k*PIX_WIDTH +: PIX_WIDTH];
      end
    end
  end

  assign result_s = (mode_r == 2'd2) ? grad_s : op_s;

  // Carries the highest lane of the previous word across a job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_pix_r <= {PIX_WIDTH{1'b0}};
      first_r    <= 1'b0;
    end else if (launch_s) begin
      first_r <= 1'b1;
    end else if (capture_s) begin
      prev_pix_r <= mgr_obi.rdata[DATA_WIDTH-1 -: PIX_WIDTH];
      first_r    <= 1'b0;
    end
  end
`else
  assign result_s = op_s;
`endif

  // Register read mux; writes and unmapped offsets return zero.
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    if (!sbr_obi.we) begin
      case (reg_idx_s)
        REG_CTRL:   rd_data_s = {{(DATA_WIDTH-3){1'b0}}, mode_r, 1'b0};
        REG_SRC:    rd_data_s = DATA_WIDTH'(src_r);
        REG_DST:    rd_data_s = DATA_WIDTH'(dst_r);
        REG_LEN:    rd_data_s = DATA_WIDTH'(len_r);
        REG_PARAM:  rd_data_s = DATA_WIDTH'(param_r);
        REG_STATUS: rd_data_s = {{(DATA_WIDTH-3){1'b0}}, err_flag_r, done_r, busy_s};
        default:    rd_data_s = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Subordinate response, one cycle after the grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbr_rvalid_r <= 1'b0;
      sbr_rdata_r  <= {DATA_WIDTH{1'b0}};
      sbr_rid_r    <= {ID_WIDTH{1'b0}};
      sbr_err_r    <= 1'b0;
    end else begin
      sbr_rvalid_r <= sbr_obi.req;
      sbr_rdata_r  <= sbr_obi.req ? rd_data_s : {DATA_WIDTH{1'b0}};
      sbr_rid_r    <= sbr_obi.req ? sbr_obi.id : {ID_WIDTH{1'b0}};
      sbr_err_r    <= sbr_obi.req & sbr_err_s;
    end
  end

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_r  <= 2'd0;
      src_r   <= {ADDR_WIDTH{1'b0}};
      dst_r   <= {ADDR_WIDTH{1'b0}};
      len_r   <= {LEN_WIDTH{1'b0}};
      param_r <= {PIX_WIDTH{1'b0}};
    end else if (cfg_wr_ok_s) begin
      case (reg_idx_s)
        REG_CTRL:  mode_r  <= sbr_obi.wdata[2:1];
        REG_SRC:   src_r   <= sbr_obi.wdata[ADDR_WIDTH-1:0];
        REG_DST:   dst_r   <= sbr_obi.wdata[ADDR_WIDTH-1:0];
        REG_LEN:   len_r   <= sbr_obi.wdata[LEN_WIDTH-1:0];
        REG_PARAM: param_r <= sbr_obi.wdata[PIX_WIDTH-1:0];
        default:   mode_r  <= mode_r;
      endcase
    end
  end

  // Sticky status flags; a hardware set beats a same-cycle W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_r     <= 1'b0;
      err_flag_r <= 1'b0;
    end else begin
      if (done_set_s) begin
        done_r <= 1'b1;
      end else if (launch_s || (status_wr_s && sbr_obi.wdata[1])) begin
        done_r <= 1'b0;
      end
      if (err_set_s) begin
        err_flag_r <= 1'b1;
      end else if (launch_s || (status_wr_s && sbr_obi.wdata[2])) begin
        err_flag_r <= 1'b0;
      end
    end
  end

  // Job pointers and remaining word count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_ptr_r <= {ADDR_WIDTH{1'b0}};
      dst_ptr_r <= {ADDR_WIDTH{1'b0}};
      remain_r  <= {LEN_WIDTH{1'b0}};
    end else if (launch_s) begin
      src_ptr_r <= src_r;
      dst_ptr_r <= dst_r;
      remain_r  <= len_r;
    end else if (wr_done_s) begin
      src_ptr_r <= src_ptr_r + ADDR_STEP;
      dst_ptr_r <= dst_ptr_r + ADDR_STEP;
      remain_r  <= remain_r - LEN_ONE;
    end
  end

  // Manager FSM: next state plus the next values of the registered request outputs.
  always_comb begin
    state_s    = state_r;
    req_s      = 1'b0;
    we_s       = 1'b0;
    addr_s     = mgr_addr_r;
    done_set_s = 1'b0;
    err_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          state_s = ST_RD_REQ;
          req_s   = 1'b1;
          addr_s  = src_r;
        end else if (start_s) begin
          done_set_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (mgr_obi.gnt) begin
          state_s = ST_RD_WAIT;
        end else begin
          req_s = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (mgr_obi.rvalid && mgr_obi.err) begin
          err_set_s  = 1'b1;
          done_set_s = 1'b1;
          state_s    = ST_IDLE;
        end else if (mgr_obi.rvalid) begin
          state_s = ST_WR_REQ;
          req_s   = 1'b1;
          we_s    = 1'b1;
          addr_s  = dst_ptr_r;
        end else begin
          state_s = ST_RD_WAIT;
        end
      end
      ST_WR_REQ: begin
        if (mgr_obi.gnt) begin
          state_s = ST_WR_WAIT;
        end else begin
          req_s = 1'b1;
          we_s  = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (mgr_obi.rvalid && mgr_obi.err) begin
          err_set_s  = 1'b1;
          done_set_s = 1'b1;
          state_s    = ST_IDLE;
        end else if (mgr_obi.rvalid) begin
          if (remain_r == LEN_ONE) begin
            done_set_s = 1'b1;
            state_s    = ST_IDLE;
          end else begin
            state_s = ST_RD_REQ;
            req_s   = 1'b1;
            addr_s  = src_ptr_r + ADDR_STEP;
          end
        end else begin
          state_s = ST_WR_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State and manager request registers; the write data is the word processed at read return.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      mgr_req_r   <= 1'b0;
      mgr_we_r    <= 1'b0;
      mgr_addr_r  <= {ADDR_WIDTH{1'b0}};
      mgr_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r    <= state_s;
      mgr_req_r  <= req_s;
      mgr_we_r   <= we_s;
      mgr_addr_r <= addr_s;
      if (capture_s) begin
        mgr_wdata_r <= result_s;
      end
    end
  end
endmodule

// File: tb/tb_user_edge_dma_accel.sv
// Scoreboard bench for user_edge_dma_accel: register responses and manager writes are checked by a monitor.
module tb_user_edge_dma_accel;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  localparam logic [31:0] A_CTRL = 32'h00, A_SRC = 32'h04, A_DST = 32'h08;
  localparam logic [31:0] A_LEN = 32'h0C, A_PARAM = 32'h10, A_STATUS = 32'h14;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  user_edge_dma_accel_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) sbr_obi ();
  user_edge_dma_accel_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) mgr_obi ();

  user_edge_dma_accel dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .sbr_obi (sbr_obi),
    .mgr_obi (mgr_obi)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  rid;
    logic        err;
    logic        chk_data;
  } sbr_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  sbr_exp_t    sbr_q[$];
  string       sbr_name_q[$];
  wr_exp_t     wr_q[$];
  logic [31:0] last_rdata;
  logic [3:0]  next_id = 4'd0;

  logic [31:0] mem [logic [31:0]];
  logic        stall = 1'b0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          cyc_count = 0;
  int          inject_rd = -1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Zero-wait SRAM responder with optional stall and read-error injection.
  assign mgr_obi.gnt = mgr_obi.req & ~stall;
  assign mgr_obi.rid = 4'd0;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mgr_obi.rvalid <= 1'b0;
      mgr_obi.err    <= 1'b0;
      mgr_obi.rdata  <= 32'd0;
    end else begin
      mgr_obi.rvalid <= mgr_obi.req & mgr_obi.gnt;
      mgr_obi.err    <= 1'b0;
      if (mgr_obi.req && mgr_obi.gnt) begin
        if (mgr_obi.we) begin
          wr_count <= wr_count + 1;
        end else begin
          mgr_obi.rdata <= mem.exists(mgr_obi.addr) ? mem[mgr_obi.addr] : 32'hDEADBEEF;
          rd_count      <= rd_count + 1;
          if (rd_count + 1 == inject_rd) mgr_obi.err <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (mgr_obi.req || mgr_obi.rvalid) cyc_count <= cyc_count + 1;
  end

  // Monitor: pops an expectation whenever the DUT presents a response or a granted write.
  always @(negedge clk_i) begin : monitor
    sbr_exp_t e;
    string    nm;
    wr_exp_t  w;
    if (sbr_obi.rvalid) begin
      if (sbr_q.size() == 0) begin
        check("sbr_unexpected", 64'(sbr_q.size()), 64'd1);
      end else begin
        e  = sbr_q.pop_front();
        nm = sbr_name_q.pop_front();
        last_rdata = sbr_obi.rdata;
        check({nm, "_rid_err"}, {sbr_obi.rid, sbr_obi.err}, {e.rid, e.err});
        if (e.chk_data) check(nm, sbr_obi.rdata, e.data);
      end
    end
    if (mgr_obi.req && mgr_obi.gnt && mgr_obi.we) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected", 64'(wr_q.size()), 64'd1);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", mgr_obi.addr, w.addr);
        check("wr_data", mgr_obi.wdata, w.data);
      end
    end
  end

  task automatic sbr_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                            input logic [31:0] exp_data, input logic exp_err, input logic chk,
                            input string name);
    sbr_exp_t e;
    @(negedge clk_i);
    sbr_obi.req   = 1'b1;
    sbr_obi.addr  = addr;
    sbr_obi.we    = we;
    sbr_obi.wdata = wdata;
    sbr_obi.id    = next_id;
    e.data = exp_data; e.rid = next_id; e.err = exp_err; e.chk_data = chk;
    sbr_q.push_back(e);
    sbr_name_q.push_back(name);
    next_id = next_id + 4'd1;
    @(posedge clk_i); #1;
    sbr_obi.req = 1'b0;
    sbr_obi.we  = 1'b0;
    @(negedge clk_i); #1;
  endtask

  task automatic reg_wr(input logic [31:0] addr, input logic [31:0] data, input logic exp_err, input string name);
    sbr_access(addr, 1'b1, data, 32'd0, exp_err, 1'b0, name);
  endtask

  task automatic reg_rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    sbr_access(addr, 1'b0, 32'd0, exp, 1'b0, 1'b1, name);
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      sbr_access(A_STATUS, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "poll");
      idle = (last_rdata[0] == 1'b0);
    end
    check({name, "_timeout"}, 64'(idle), 64'd1);
  endtask

  task automatic start_job(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                           input logic [31:0] ctrl);
    reg_wr(A_SRC, src, 1'b0, "wr_src");
    reg_wr(A_DST, dst, 1'b0, "wr_dst");
    reg_wr(A_LEN, len, 1'b0, "wr_len");
    reg_wr(A_CTRL, ctrl, 1'b0, "wr_ctrl");
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
    wr_exp_t w;
    w.addr = addr; w.data = data;
    wr_q.push_back(w);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (mgr_obi.req) break;
      @(negedge clk_i);
    end
  endtask

  initial begin
    int          base;
    logic [31:0] g0, g1, cap_wdata;
    sbr_obi.req = 1'b0; sbr_obi.addr = 32'd0; sbr_obi.wdata = 32'd0;
    sbr_obi.we = 1'b0; sbr_obi.id = 4'd0;
    mem[32'h1000] = 32'h11223344; mem[32'h1004] = 32'h55667788;
    mem[32'h1100] = 32'h80402010;
    mem[32'h1180] = 32'h7F80FF00;
    mem[32'h1200] = 32'h40302010; mem[32'h1204] = 32'h00000050;
    mem[32'h1300] = 32'hA1A2A3A4; mem[32'h1304] = 32'hB1B2B3B4; mem[32'h1308] = 32'hC1C2C3C4;
    mem[32'h1400] = 32'h01020304; mem[32'h1404] = 32'h05060708;
    mem[32'h1500] = 32'hCAFEF00D;

    repeat (3) @(negedge clk_i);
    check("rst_mgr_ctl", {mgr_obi.req, mgr_obi.we, mgr_obi.id, mgr_obi.addr}, 64'd0);
    check("rst_mgr_wdata", mgr_obi.wdata, 64'd0);
    check("rst_sbr", {sbr_obi.rvalid, sbr_obi.err, sbr_obi.rid, sbr_obi.rdata}, 64'd0);
    rst_ni = 1'b1;
    reg_rd(A_STATUS, 32'd0, "reset_status");
    reg_rd(A_SRC, 32'd0, "reset_src");
    sbr_access(32'h18, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, "bad_offset");

    // copy
    push_wr(32'h2000, 32'h11223344);
    push_wr(32'h2004, 32'h55667788);
    base = cyc_count;
    start_job(32'h1000, 32'h2000, 32'd2, 32'h1);
    wait_idle("copy");
    check("copy_cycles", 64'(cyc_count - base), 64'd8);
    reg_rd(A_STATUS, 32'h2, "copy_status");
    reg_rd(A_CTRL, 32'h0, "copy_ctrl");

    // shift by 2
    reg_wr(A_PARAM, 32'd2, 1'b0, "wr_param");
    push_wr(32'h2100, 32'h20100804);
    start_job(32'h1100, 32'h2100, 32'd1, 32'h3);
    wait_idle("shift");
    reg_rd(A_CTRL, 32'h2, "shift_ctrl");

    // threshold at 0x80
    reg_wr(A_PARAM, 32'h80, 1'b0, "wr_param");
    push_wr(32'h2180, 32'h00FFFF00);
    start_job(32'h1180, 32'h2180, 32'd1, 32'h7);
    wait_idle("thresh");
    reg_rd(A_PARAM, 32'h80, "thresh_param");

    // gradient (copy when the feature is compiled out)
`ifdef USER_EDGE_GRAD_EN
    g0 = 32'h10101000; g1 = 32'h00005010;
`else
    g0 = 32'h40302010; g1 = 32'h00000050;
`endif
    push_wr(32'h2200, g0);
    push_wr(32'h2204, g1);
    start_job(32'h1200, 32'h2200, 32'd2, 32'h5);
    wait_idle("grad");
    reg_rd(A_STATUS, 32'h2, "grad_status");

    // LEN=0 sets DONE with no traffic
    reg_wr(A_STATUS, 32'h6, 1'b0, "w1c");
    reg_rd(A_STATUS, 32'h0, "w1c_status");
    base = cyc_count;
    start_job(32'h1000, 32'h2F00, 32'd0, 32'h1);
    repeat (8) @(negedge clk_i);
    check("len0_traffic", 64'(cyc_count - base), 64'd0);
    reg_rd(A_STATUS, 32'h2, "len0_status");

    // read error on the second read of a 3-word copy
    inject_rd = rd_count + 2;
    base = wr_count;
    push_wr(32'h2300, 32'hA1A2A3A4);
    start_job(32'h1300, 32'h2300, 32'd3, 32'h1);
    wait_idle("err");
    inject_rd = -1;
    reg_rd(A_STATUS, 32'h6, "err_status");
    check("err_writes", 64'(wr_count - base), 64'd1);
    reg_wr(A_STATUS, 32'h6, 1'b0, "w1c");
    reg_rd(A_STATUS, 32'h0, "err_cleared");

    // stalled grant: request held stable, config writes refused while busy
    stall = 1'b1;
    start_job(32'h1400, 32'h2400, 32'd2, 32'h1);
    wait_req();
    cap_wdata = mgr_obi.wdata;
    repeat (5) begin
      check("stall_ctl", {mgr_obi.req, mgr_obi.we, mgr_obi.addr}, {1'b1, 1'b0, 32'h1400});
      check("stall_wdata", mgr_obi.wdata, cap_wdata);
      @(negedge clk_i);
    end
    reg_wr(A_SRC, 32'h9999, 1'b1, "src_busy");
    reg_rd(A_STATUS, 32'h1, "status_busy");
    push_wr(32'h2400, 32'h01020304);
    push_wr(32'h2404, 32'h05060708);
    stall = 1'b0;
    wait_idle("stall");
    reg_rd(A_SRC, 32'h1400, "src_kept");

    // reset in the middle of a stalled job
    stall = 1'b1;
    start_job(32'h1500, 32'h2500, 32'd4, 32'h1);
    wait_req();
    check("rst_job_active", 64'(mgr_obi.req), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("midrst_mgr_ctl", {mgr_obi.req, mgr_obi.we, mgr_obi.id, mgr_obi.addr}, 64'd0);
    check("midrst_mgr_wdata", mgr_obi.wdata, 64'd0);
    check("midrst_sbr", {sbr_obi.rvalid, sbr_obi.err, sbr_obi.rid, sbr_obi.rdata}, 64'd0);
    stall = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    reg_rd(A_STATUS, 32'h0, "midrst_status");
    reg_rd(A_LEN, 32'h0, "midrst_len");
    repeat (4) @(negedge clk_i);

    check("sbr_pending", 64'(sbr_q.size()), 64'd0);
    check("wr_pending", 64'(wr_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
